// File: rtl/mig_ui_bram_model_if.sv
// mig_ui_bram_model_if: MIG 7-series app_* user-interface bundle.
// master = user logic side (mem/mux), slave = memory controller side.
interface mig_ui_bram_model_if #(
    parameter int ADDR_WIDTH     = 29,
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_MASK_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]     app_addr;
    logic [2:0]                app_cmd;
    logic                      app_en;
    logic                      app_rdy;
    logic [APP_DATA_WIDTH-1:0] app_wdf_data;
    logic [APP_MASK_WIDTH-1:0] app_wdf_mask;
    logic                      app_wdf_wren;
    logic                      app_wdf_end;
    logic                      app_wdf_rdy;
    logic [APP_DATA_WIDTH-1:0] app_rd_data;
    logic                      app_rd_data_valid;
    logic                      app_rd_data_end;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
    );
    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
    );
endinterface

// File: rtl/mig_ui_bram_model.sv
// mig_ui_bram_model: block-RAM stand-in for the 7-series MIG user interface.
// Define MIG_MODEL_REFRESH_STALL_EN to drop app_rdy for 8 cycles every 1024 cycles.
module mig_ui_bram_model #(
    parameter int ADDR_WIDTH     = 29,
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_MASK_WIDTH = 16,
    parameter int DEPTH_LOG2     = 10,
    parameter int CALIB_CYCLES   = 64,
    parameter int RD_LATENCY     = 4
) (
    input  logic clk,
    input  logic rst,
    mig_ui_bram_model_if.slave app,
    output logic init_calib_complete,
    output logic cmd_err
);
    localparam int CW = $clog2(CALIB_CYCLES + 1);
    typedef logic [DEPTH_LOG2-1:0] row_t;

    logic [APP_DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
    logic [2:0]                cq_cmd [4];
    row_t                      cq_row [4];
    logic [APP_DATA_WIDTH-1:0] wq_data [4];
    logic [APP_MASK_WIDTH-1:0] wq_mask [4];
    logic [1:0]                cq_wp, cq_rp, wq_wp, wq_rp;
    logic [2:0]                cq_cnt, wq_cnt;
    logic [CW-1:0]             cal_cnt;
    logic [2:0]                head_cmd;
    logic                      stall, cmd_push, wdf_push, cmd_pop, exec_wr, exec_rd;
    logic [APP_DATA_WIDTH-1:0] rd_q;
    logic [RD_LATENCY:0]       pv;
    logic [APP_DATA_WIDTH-1:0] pd [RD_LATENCY];
    logic                      unused_ok;

    assign unused_ok = &{1'b0, app.app_wdf_end, app.app_addr};

    // Ready comes only from registered full flags, never from same-cycle pops.
    assign app.app_rdy     = init_calib_complete & ~cq_cnt[2] & ~stall;
    assign app.app_wdf_rdy = init_calib_complete & ~wq_cnt[2];
    assign cmd_push        = app.app_en & app.app_rdy;
    assign wdf_push        = app.app_wdf_wren & app.app_wdf_rdy;

    assign head_cmd = cq_cmd[cq_rp];
    assign exec_wr  = |cq_cnt && head_cmd == 3'b000 && |wq_cnt;
    assign exec_rd  = |cq_cnt && head_cmd == 3'b001;
    assign cmd_pop  = exec_wr || exec_rd || (|cq_cnt && |head_cmd[2:1]);

    assign app.app_rd_data_valid = pv[RD_LATENCY];
    assign app.app_rd_data_end   = pv[RD_LATENCY];
    assign app.app_rd_data       = pd[RD_LATENCY-1];

`ifdef MIG_MODEL_REFRESH_STALL_EN
    logic [9:0] ref_cnt;
    logic       ref_wrapped;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_cnt     <= '0;
            ref_wrapped <= 1'b0;
        end else if (init_calib_complete) begin
            ref_cnt <= ref_cnt + 1'b1;
            if (&ref_cnt) ref_wrapped <= 1'b1;
        end
    end
    assign stall = ref_wrapped & (ref_cnt < 10'd8);
`else
    assign stall = 1'b0;
`endif

    // Storage is left unreset so it maps onto block RAM / distributed RAM.
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cq_cmd[cq_wp] <= app.app_cmd;
            cq_row[cq_wp] <= app.app_addr[DEPTH_LOG2+2:3];
        end
        if (wdf_push) begin
            wq_data[wq_wp] <= app.app_wdf_data;
            wq_mask[wq_wp] <= app.app_wdf_mask;
        end
        if (exec_rd) rd_q <= mem[cq_row[cq_rp]];
        for (int b = 0; b < APP_MASK_WIDTH; b++)
            if (exec_wr && !wq_mask[wq_rp][b]) mem[cq_row[cq_rp]][8*b +: 8] <= wq_data[wq_rp][8*b +: 8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cal_cnt             <= '0;
            init_calib_complete <= 1'b0;
            cmd_err             <= 1'b0;
            cq_wp               <= '0;
            cq_rp               <= '0;
            wq_wp               <= '0;
            wq_rp               <= '0;
            cq_cnt              <= '0;
            wq_cnt              <= '0;
            pv                  <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pd[i] <= '0;
        end else begin
            if (!init_calib_complete) begin
                cal_cnt             <= cal_cnt + 1'b1;
                init_calib_complete <= cal_cnt == CW'(CALIB_CYCLES - 1);
            end
            if (cmd_push) cq_wp <= cq_wp + 1'b1;
            if (cmd_pop) cq_rp <= cq_rp + 1'b1;
            if (wdf_push) wq_wp <= wq_wp + 1'b1;
            if (exec_wr) wq_rp <= wq_rp + 1'b1;
            cq_cnt <= cq_cnt + {2'b0, cmd_push} - {2'b0, cmd_pop};
            wq_cnt <= wq_cnt + {2'b0, wdf_push} - {2'b0, exec_wr};
            if (cmd_pop && !exec_wr && !exec_rd) cmd_err <= 1'b1;
            // Data stages load only on valid so app_rd_data holds between beats.
            pv <= {pv[RD_LATENCY-1:0], exec_rd};
            if (pv[0]) pd[0] <= rd_q;
            for (int i = 1; i < RD_LATENCY; i++)
                if (pv[i]) pd[i] <= pd[i-1];
        end
    end
endmodule
